// File: rtl/elevator_scan_ctrl_if.sv
// Car controller bundle: call/sensor inputs from the panel, position and status back out.
interface elevator_scan_ctrl_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);
  logic [FLOORS-1:0]  call_btn;
  logic               sos;
  logic               overweight;
  logic [FLOORS-1:0]  call_led;
  logic [FLOOR_W-1:0] floor_idx;
  logic [FLOORS-1:0]  floor_onehot;
  logic               door_open;
  logic               moving;
  logic               dir_up;
  logic               sos_mode;
  logic               weight_limit_exceeded;

  modport master (
    output call_btn, sos, overweight,
    input  call_led, floor_idx, floor_onehot, door_open, moving, dir_up,
           sos_mode, weight_limit_exceeded
  );
  modport slave (
    input  call_btn, sos, overweight,
    output call_led, floor_idx, floor_onehot, door_open, moving, dir_up,
           sos_mode, weight_limit_exceeded
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator car controller: latches calls, runs door/move timers,
// handles SOS halt and overweight departure inhibit.
module elevator_scan_ctrl #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int MOVE_TICKS = 5,
  parameter int DOOR_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  elevator_scan_ctrl_if.slave bus
);
  localparam int MT_W = $clog2(MOVE_TICKS + 1);
  localparam int DT_W = $clog2(DOOR_TICKS + 1);
  localparam logic [MT_W-1:0]    MT   = MT_W'(MOVE_TICKS);
  localparam logic [DT_W-1:0]    DT   = DT_W'(DOOR_TICKS);
  localparam logic [FLOOR_W-1:0] TOPF = FLOOR_W'(FLOORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DOOR, S_MOVING, S_HALT} st_e;

  st_e                state;
  logic [FLOORS-1:0]  call_led;
  logic [FLOOR_W-1:0] floor_idx;
  logic [MT_W-1:0]    move_tmr;
  logic [DT_W-1:0]    door_tmr;
  logic               door_open, moving, dir_up, sos_mode, wle;

  logic [FLOORS-1:0]  oh, nxt_oh, btn_set, calls;
  logic [FLOOR_W-1:0] nxt;
  logic               here_served, above, below, nxt_above, nxt_below;
  logic               ahead, behind, nxt_ahead, stop;

  always_comb begin
    oh = '0;
    oh[floor_idx] = 1'b1;
    nxt = floor_idx;
    if (dir_up && floor_idx != TOPF)     nxt = floor_idx + 1'b1;
    else if (!dir_up && floor_idx != '0) nxt = floor_idx - 1'b1;
    nxt_oh = '0;
    nxt_oh[nxt] = 1'b1;
    btn_set = sos_mode ? '0 : bus.call_btn;
    here_served = 1'b0;
    // A call at the floor where the door is already open is served on the spot.
    if (state == S_IDLE || state == S_DOOR) begin
      here_served = |(btn_set & oh);
      btn_set     = btn_set & ~oh;
    end
    calls = call_led | btn_set;
    above = 1'b0; below = 1'b0; nxt_above = 1'b0; nxt_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_idx) above     = above | call_led[i];
      if (FLOOR_W'(i) < floor_idx) below     = below | call_led[i];
      if (FLOOR_W'(i) > nxt)       nxt_above = nxt_above | calls[i];
      if (FLOOR_W'(i) < nxt)       nxt_below = nxt_below | calls[i];
    end
    ahead     = dir_up ? above : below;
    behind    = dir_up ? below : above;
    nxt_ahead = dir_up ? nxt_above : nxt_below;
    stop = (|(calls & nxt_oh)) | !nxt_ahead | (nxt == '0) | (nxt == TOPF) | sos_mode | bus.sos;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      call_led  <= '0;
      floor_idx <= '0;
      move_tmr  <= '0;
      door_tmr  <= '0;
      door_open <= 1'b1;
      moving    <= 1'b0;
      dir_up    <= 1'b1;
      sos_mode  <= 1'b0;
      wle       <= 1'b0;
    end else begin
      wle <= bus.overweight;
      case (state)
        S_IDLE: begin
          call_led <= calls;
          if (here_served) door_tmr <= DT;
          if (bus.sos) begin
            state <= S_HALT; sos_mode <= 1'b1; call_led <= '0;
          end else if (ahead) begin
            state <= S_DOOR; door_tmr <= DT;
          end else if (behind) begin
            state <= S_DOOR; door_tmr <= DT; dir_up <= ~dir_up;
          end
        end
        S_DOOR: begin
          call_led <= calls;
          if (bus.sos) begin
            state <= S_HALT; sos_mode <= 1'b1; call_led <= '0;
          end else if (wle || here_served) begin
            door_tmr <= DT;
          end else if (door_tmr > DT_W'(1)) begin
            door_tmr <= door_tmr - 1'b1;
          end else if (ahead) begin
            state <= S_MOVING; door_open <= 1'b0; moving <= 1'b1; move_tmr <= MT;
          end else if (behind) begin
            dir_up <= ~dir_up; door_tmr <= DT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_MOVING: begin
          // SOS is only latched here; the segment always completes.
          sos_mode <= sos_mode | bus.sos;
          call_led <= calls;
          if (move_tmr > MT_W'(1)) begin
            move_tmr <= move_tmr - 1'b1;
          end else begin
            floor_idx <= nxt;
            if (stop) begin
              moving <= 1'b0; door_open <= 1'b1;
              if (sos_mode || bus.sos) begin
                state <= S_HALT; sos_mode <= 1'b1; call_led <= '0;
              end else begin
                state <= S_DOOR; door_tmr <= DT; call_led <= calls & ~nxt_oh;
              end
            end else begin
              move_tmr <= MT;
            end
          end
        end
        S_HALT: begin
          call_led <= '0;
          if (!bus.sos) begin
            state <= S_IDLE; sos_mode <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.call_led              = call_led;
  assign bus.floor_idx             = floor_idx;
  assign bus.floor_onehot          = oh;
  assign bus.door_open             = door_open;
  assign bus.moving                = moving;
  assign bus.dir_up                = dir_up;
  assign bus.sos_mode              = sos_mode;
  assign bus.weight_limit_exceeded = wle;
endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised next-generation car controller; replaces the fixed 3-floor movement/goal/door/buttons cluster.
- Latches hall/car calls for FLOORS floors and serves them in SCAN order: keep direction while calls remain ahead, then reverse.
- Owns the door and move timers, the SOS halt and the overweight departure inhibit.
- Outputs one-hot and binary floor position, call LEDs and status to the display and indicator logic.

Parameters:
FLOORS, 4, number of floors (2..16); floor 0 is the bottom.
FLOOR_W, 2, width of floor_idx; must be >= clog2(FLOORS).
MOVE_TICKS, 5, clk cycles to travel one floor (>=1).
DOOR_TICKS, 2, clk cycles door stays open before departure (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
call_btn  in  FLOORS  call buttons, level, bit i = floor i.
sos  in  1  emergency stop request, level.
overweight  in  1  load sensor, level.
call_led  out  FLOORS  latched pending calls.
floor_idx  out  FLOOR_W  current or last-passed floor, binary.
floor_onehot  out  FLOORS  one-hot of floor_idx.
door_open  out  1  door open.
moving  out  1  car travelling.
dir_up  out  1  current/last direction; 1 = up.
sos_mode  out  1  SOS active or pending.
weight_limit_exceeded  out  1  registered overweight.

Behaviour:
- All state changes on posedge clk. rst_n=0 at an edge forces state IDLE, floor_idx=0, floor_onehot=1, call_led=0, door_open=1, moving=0, dir_up=1, sos_mode=0, weight_limit_exceeded=0, both timers cleared. This applies mid-move too: the car snaps to floor 0.
- weight_limit_exceeded = overweight delayed one cycle. sos_mode is registered.
- Call latching:
  - call_led[i] sets on any cycle call_btn[i]=1 while sos_mode=0.
  - Exception: i == floor_idx while state is IDLE or DOOR. That call is served at once: not latched, and the door timer reloads.
  - A call at floor_idx during MOVING latches normally.
  - call_led[i] clears on the arrival cycle at floor i when the car stops there.
- ahead = any call_led above floor_idx when dir_up=1, else any below. behind = the opposite.
- States:
  - IDLE: door_open=1, moving=0.
    - sos=1 -> HALT.
    - ahead -> DOOR with timer loaded DOOR_TICKS.
    - else behind -> toggle dir_up, then DOOR.
    - If both ahead and behind, ahead wins.
  - DOOR: door_open=1. The timer decrements each cycle.
    - While weight_limit_exceeded=1, the timer holds at DOOR_TICKS.
    - sos=1 -> HALT.
    - At timer 0: ahead -> MOVING (door_open=0, moving=1, move timer=MOVE_TICKS); else behind -> toggle dir_up and stay DOOR with timer reloaded; else -> IDLE.
  - MOVING: the move timer decrements. At 0, floor_idx += dir_up ? 1 : -1 (arrival cycle).
    - Stop (-> DOOR, moving=0, door_open=1, timer reloaded) if any of: call_led[new floor]=1, no call ahead of the new floor, new floor is a terminal (0 or FLOORS-1), or sos_mode=1.
    - Otherwise reload the move timer and continue.
    - A stop with sos_mode=1 goes to HALT instead of DOOR.
    - sos never aborts a segment mid-travel: sos_mode sets immediately and the halt takes effect at arrival.
  - HALT: door_open=1, moving=0, sos_mode=1, call_led forced to 0, buttons ignored.
    - Exit to IDLE on the first cycle sos=0. sos_mode clears the same cycle.
- floor_idx never leaves 0..FLOORS-1; no wrap-around.
- Simultaneous: a call at the arrival floor on the arrival cycle counts as a stop request. A press on the same cycle as a clear leaves the bit cleared.

Test Plan:
- Reset, FLOORS=4, press call_btn[3] 1 cycle -> DOOR 2 cycles, MOVING, floor_idx 1,2,3 at 5-cycle intervals; stops at 3 with door_open=1 and call_led=0000.
- Car at 0 moving up: press calls 2 and 1 -> stops at 1, then 2, call_led clears per stop; dir_up stays 1.
- Car at 2 idle, calls at 3 and 0 with dir_up=1 -> serves 3 first, reverses, reaches 0; dir_up=0 at the end.
- Calls at 2 and 0 with dir_up=1 and car at 1 in DOOR, overweight=1 for 10 cycles -> door_open stays 1 and no departure; departure exactly DOOR_TICKS cycles after overweight drops.
- sos=1 mid-segment 0->1 -> sos_mode=1 next cycle, arrival at floor 1 after remaining ticks, HALT, call_led=0, buttons ignored; sos=0 -> IDLE.
- rst_n=0 during MOVING at floor 2 -> next edge floor_idx=0, moving=0, door_open=1, call_led=0.
